// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin owner of a shared 2-to-4 decoder with done/withdraw/hold-limit release
module rr_decoder_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic       dec_en,
   output logic [1:0] dec_sel,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       timeout
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t     r_state;
   logic       r_dec_en;
   logic       r_timeout;
   logic [1:0] r_dec_sel;
   logic [1:0] r_last;
   logic [3:0] r_gnt;
   logic [7:0] r_cnt;
   logic [1:0] w_win;
   logic       w_limit;
   logic       w_release;
   // scan last+4 down to last+1 so the nearest set bit after last wins
   always_comb begin
      w_win = r_last + 2'd1;
      for (int i = 4; i >= 1; i--)
         if (req[r_last + 2'(i)]) w_win = r_last + 2'(i);
   end
   assign w_limit   = r_cnt == 8'(MAX_HOLD - 1);
   assign w_release = done | ~req[r_dec_sel] | w_limit;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_dec_en  <= 1'b0;
         r_dec_sel <= 2'd0;
         r_gnt     <= 4'd0;
         r_timeout <= 1'b0;
         r_last    <= 2'd3;
         r_cnt     <= 8'd0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            GRANT: begin
               r_cnt <= (r_cnt == 8'hff) ? r_cnt : r_cnt + 8'd1;
               if (w_release) begin
                  r_state   <= RELEASE;
                  r_dec_en  <= 1'b0;
                  r_gnt     <= 4'd0;
                  r_last    <= r_dec_sel;
                  r_timeout <= w_limit & ~done & req[r_dec_sel];
               end
            end
            default: begin
               r_state <= (|req) ? GRANT : IDLE;
               if (|req) begin
                  r_dec_en  <= 1'b1;
                  r_dec_sel <= w_win;
                  r_gnt     <= 4'b0001 << w_win;
                  r_cnt     <= 8'd0;
               end
            end
         endcase
      end
   end
   assign dec_en  = r_dec_en;
   assign dec_sel = r_dec_sel;
   assign gnt     = r_gnt;
   assign busy    = r_dec_en;
   assign timeout = r_timeout;
endmodule
